tl_master: RTL
==============

# tl_master

Initiator end of the single-beat A/D channel link. Takes one read or write command at a time from the processor side, issues a Get or PutFullData on the A channel, and waits for the matching D-channel response. It then returns read data and error status to the requester. It pairs with the memory slave on the same 53-bit A and 43-bit D channel layout.

## Interface
- a_channel_size, 53, A channel width: opcode[52:50] param[49:47] size[46:44] source[43:42] address[41:32] data[31:0]
- d_channel_size, 43, D channel width: opcode[42:40] param[39:37] size[36:34] source[33:32] data[31:0]
- SOURCE_ID, 0, 2-bit value driven on a_source and expected on d_source
- A_SIZE, 5, 3-bit value driven on a_size
- TIMEOUT_CYCLES, 255, response watchdog limit (16-bit), used only with the macro below
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = PutFullData, 0 = Get
- cmd_addr  in  10  word address
- cmd_wdata  in  32  write data; ignored for reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data; 0 for writes
- rsp_error  out  1  response error flag, qualified by rsp_valid
- a_channel  out  53  A-channel payload
- a_valid  out  1  A beat valid
- a_ready  in  1  A beat accepted when a_valid && a_ready
- d_channel  in  43  D-channel payload
- d_valid  in  1  D beat valid; may last only one cycle
- d_ready  out  1  master able to take a D beat
- backpressureslave  in  1  slave busy
- d_error  in  1  slave-reported error, sampled with d_valid

## Operation
- States: IDLE, SEND_A, WAIT_D.
- All outputs are registered, except cmd_ready = (state==IDLE) && !backpressureslave.
- Reset: state IDLE; a_channel 0, a_valid 0, d_ready 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, timeout counter 0.
- IDLE → SEND_A on a command handshake. On that edge:
  - Latch the opcode: 0 when cmd_write=1, 4 when cmd_write=0.
  - Drive param 0, size A_SIZE, source SOURCE_ID, address cmd_addr.
  - Drive data cmd_wdata for writes and 0 for reads.
  - Set a_valid to 1.
- SEND_A: a_channel and a_valid are held. On a_valid && a_ready: a_valid←0, d_ready←1, go to WAIT_D.
- WAIT_D: a_channel is held unchanged, because the slave samples address and data when it responds.
- WAIT_D, d_valid=1: capture the beat, then d_ready←0, rsp_valid←1, go to IDLE.
  - rsp_rdata ← d_channel[31:0] for a Get, 0 for a Put.
  - rsp_error ← d_error, OR d_source≠SOURCE_ID, OR d_opcode≠expected (1 for a Get, 0 for a Put).
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_error hold their value until the next response.
- d_valid outside WAIT_D is ignored.
- backpressureslave blocks new commands only. It does not affect SEND_A or WAIT_D.

## Timing
- Command accepted at edge N: a_valid=1 after edge N.
- a_ready=1 sampled at edge M: a_valid=0 and d_ready=1 after edge M.
- d_valid sampled at edge K: rsp_valid=1 and state IDLE after edge K. cmd_ready can be 1 in the same cycle as rsp_valid.
- Minimum command-to-response latency is 3 edges: accept, A handshake, D capture.
- Back-to-back commands: a new command can be accepted in the cycle rsp_valid is high.
- Reset asserted mid-transaction:
  - All outputs go to their reset values immediately, without waiting for clk.
  - The in-flight transaction is dropped and no rsp_valid is generated.
  - Operation resumes from IDLE on the first edge after reset is released.

## Configuration
- TL_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_D and increments each cycle in WAIT_D without d_valid.
  - When the counter reaches TIMEOUT_CYCLES: rsp_valid←1, rsp_error←1, rsp_rdata←0, d_ready←0, go to IDLE.
  - If d_valid arrives on the same edge as the timeout, d_valid wins and the response is normal.
- TL_MASTER_TIMEOUT_EN undefined: no counter, and WAIT_D waits indefinitely.

## Test plan
- Write: cmd_write=1, addr 0x00A, wdata 0xDEADBEEF, a_ready=1 → a_channel opcode 0, address 0x00A, data 0xDEADBEEF, size 5; D beat opcode 0 → rsp_valid pulse, rsp_error 0, rsp_rdata 0.
- Read after write: Get at 0x00A against the slave model with random 1–4 cycle response delay → a_channel opcode 4; rsp_rdata 0xDEADBEEF, rsp_error 0.
- Opcode mismatch: Get answered with d_opcode 0 → rsp_error 1. Separately, d_error=1 on a valid beat → rsp_error 1.
- Stall and backpressure:
  - Hold a_ready=0 for 5 cycles → a_valid and a_channel stay stable, d_ready=0.
  - backpressureslave=1 in IDLE → cmd_ready=0 and no A beat.
- Reset driven to 0 asynchronously in WAIT_D → a_valid, d_ready and rsp_valid are 0 before the next edge; no response; a fresh Get completes normally afterwards.
- With TL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no d_valid → rsp_error 1 exactly 8 cycles after entering WAIT_D. With d_valid on the 8th cycle → normal response, rsp_error 0.

Source files
------------

// File: rtl/tl_master.sv
// tl_master: initiator end of the single-beat A/D channel link.
// Takes one command at a time, issues Get / PutFullData on A, waits for D,
// then returns read data and error status as a one-cycle response pulse.
// Optional build macro: TL_MASTER_TIMEOUT_EN adds a response watchdog in WAIT_D.
//
// state  | meaning
// IDLE   | ready for a command (unless the slave reports backpressure)
// SEND_A | A beat presented, waiting for a_ready
// WAIT_D | A beat taken, d_ready high, waiting for the D response
module tl_master #(
  parameter int          a_channel_size = 53,
  parameter int          d_channel_size = 43,
  parameter logic [1:0]  SOURCE_ID      = 2'd0,
  parameter logic [2:0]  A_SIZE         = 3'd5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [9:0]                cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error,
  output logic [a_channel_size-1:0] a_channel,
  output logic                      a_valid,
  input  logic                      a_ready,
  input  logic [d_channel_size-1:0] d_channel,
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic                      backpressureslave,
  input  logic                      d_error
);

  typedef enum logic [1:0] {IDLE, SEND_A, WAIT_D} state_t;

  localparam logic [2:0] OP_PUT      = 3'd0;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  state_t                    state, state_nx;
  logic [a_channel_size-1:0] a_channel_nx;
  logic                      a_valid_nx, d_ready_nx, rsp_valid_nx, rsp_error_nx;
  logic [31:0]               rsp_rdata_nx;
  logic                      is_get;
  logic [2:0]                d_opcode;
  logic [1:0]                d_source;
  logic [2:0]                exp_d_opcode;
  logic                      unused_d_fields;

`ifdef TL_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_cnt_nx, tmo_cnt_inc;
  assign tmo_cnt_inc = tmo_cnt + 16'd1;
`else
  localparam logic [15:0] unused_timeout = TIMEOUT_CYCLES;
`endif

  // The held A opcode tells us what kind of response to expect.
  assign is_get          = (a_channel[52:50] == OP_GET);
  assign d_opcode        = d_channel[42:40];
  assign d_source        = d_channel[33:32];
  assign exp_d_opcode    = is_get ? OP_ACK_DATA : OP_ACK;
  assign unused_d_fields = ^d_channel[39:34];
  assign cmd_ready       = (state == IDLE) && !backpressureslave;

  // Next-state and next-output computation; registers hold by default.
  always_comb begin
    state_nx     = state;
    a_channel_nx = a_channel;
    a_valid_nx   = a_valid;
    d_ready_nx   = d_ready;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    rsp_error_nx = rsp_error;
`ifdef TL_MASTER_TIMEOUT_EN
    tmo_cnt_nx   = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_channel_nx = {(cmd_write ? OP_PUT : OP_GET), 3'd0, A_SIZE, SOURCE_ID,
                          cmd_addr, (cmd_write ? cmd_wdata : 32'd0)};
          a_valid_nx   = 1'b1;
          state_nx     = SEND_A;
        end
      end
      SEND_A: begin
        if (a_ready) begin
          a_valid_nx = 1'b0;
          d_ready_nx = 1'b1;
          state_nx   = WAIT_D;
`ifdef TL_MASTER_TIMEOUT_EN
          tmo_cnt_nx = 16'd0;
`endif
        end
      end
      WAIT_D: begin
        // a_channel stays driven: the slave samples address and data here.
        if (d_valid) begin
          d_ready_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = is_get ? d_channel[31:0] : 32'd0;
          rsp_error_nx = d_error || (d_source != SOURCE_ID) || (d_opcode != exp_d_opcode);
          state_nx     = IDLE;
        end
`ifdef TL_MASTER_TIMEOUT_EN
        else begin
          tmo_cnt_nx = tmo_cnt_inc;
          if (tmo_cnt_inc == TIMEOUT_CYCLES) begin
            d_ready_nx   = 1'b0;
            rsp_valid_nx = 1'b1;
            rsp_rdata_nx = 32'd0;
            rsp_error_nx = 1'b1;
            state_nx     = IDLE;
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      a_channel <= '0;
      a_valid   <= 1'b0;
      d_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
      tmo_cnt   <= 16'd0;
`endif
    end else begin
      state     <= state_nx;
      a_channel <= a_channel_nx;
      a_valid   <= a_valid_nx;
      d_ready   <= d_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_error <= rsp_error_nx;
`ifdef TL_MASTER_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_nx;
`endif
    end
  end

endmodule
